hazard_unit: RTL and testbench

Decode-stage hazard controller for the 5-stage MIPS pipeline. It consumes the D-stage instruction word and its 2-bit `optype` classification, and tracks register destinations in flight through E/M/W in an internal scoreboard. It produces stall, flush and forwarding controls for the IF/ID and ID/EX registers, plus a saturating stall counter for performance measurement.

---
 rtl/hazard_if.sv | 32 +++
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bundle: D-stage instruction/class/branch inputs,
// stall/flush/forward controls and the stall counter.
interface hazard_if #(
  parameter int STALL_CNT_W = 16
) ();
  logic [31:0]            InstructionD;
  logic [1:0]             optype;
  logic                   PCSrcD;
  logic                   StallF;
  logic                   StallD;
  logic                   FlushD;
  logic                   FlushE;
  logic                   ForwardAD;
  logic                   ForwardBD;
  logic [1:0]             ForwardAE;
  logic [1:0]             ForwardBE;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output InstructionD, optype, PCSrcD,
    input  StallF, StallD, FlushD, FlushE,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    input  StallCount
  );

  modport slave (
    input  InstructionD, optype, PCSrcD,
    output StallF, StallD, FlushD, FlushE,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    output StallCount
  );
endinterface

// File: rtl/hazard_unit.sv
// Decode-stage hazard controller: E/M/W destination scoreboard, stall,
// flush and forward controls, saturating stall-cycle counter.
// Ports: clk, reset (sync, active-high), hz (hazard_if.slave bundle).
module hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic    clk,
  input  logic    reset,
  hazard_if.slave hz
);

  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    logic       ld;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  sb_t e_q, m_q, w_q;
  sb_t d_ent;
  logic [STALL_CNT_W-1:0] cnt_q;

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic use_rs, use_rt, is_beq;
  logic lwstall, branchstall, stall;
  logic fad, fbd;
  logic [1:0] fae, fbe;

  assign op = hz.InstructionD[31:26];
  assign rs = hz.InstructionD[25:21];
  assign rt = hz.InstructionD[20:16];
  assign rd = hz.InstructionD[15:11];

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    unique case (1'b1)
      hz.optype == 2'b10: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      hz.optype == 2'b01: begin
        use_rs = 1'b1;
        use_rt = (op == OP_SW) || (op == OP_BEQ);
      end
      default: ;
    endcase
  end

  assign is_beq = (hz.optype == 2'b01) && (op == OP_BEQ);

  // R-type destination takes precedence over a coincident lw opcode.
  always_comb begin
    d_ent = '0;
    d_ent.rs = use_rs ? rs : 5'd0;
    d_ent.rt = use_rt ? rt : 5'd0;
    if (hz.optype == 2'b10) begin
      d_ent.wr  = 1'b1;
      d_ent.dst = rd;
    end else if (op == OP_LW) begin
      d_ent.wr  = 1'b1;
      d_ent.dst = rt;
      d_ent.ld  = 1'b1;
    end
  end

  always_comb begin
    lwstall = e_q.ld && e_q.wr && (e_q.dst != 5'd0) &&
              ((use_rs && (e_q.dst == rs)) ||
               (use_rt && (e_q.dst == rt)));
    branchstall = is_beq && (
      (e_q.wr && (e_q.dst != 5'd0) &&
       ((e_q.dst == rs) || (e_q.dst == rt))) ||
      (m_q.ld && (m_q.dst != 5'd0) &&
       ((m_q.dst == rs) || (m_q.dst == rt))));
    stall = !reset && (lwstall || branchstall);
  end

  always_comb begin
    fad = (rs != 5'd0) && m_q.wr && !m_q.ld && (m_q.dst == rs);
    fbd = (rt != 5'd0) && m_q.wr && !m_q.ld && (m_q.dst == rt);

    fae = 2'b00;
    if ((e_q.rs != 5'd0) && m_q.wr && (m_q.dst == e_q.rs))
      fae = 2'b10;
    else if ((e_q.rs != 5'd0) && w_q.wr && (w_q.dst == e_q.rs))
      fae = 2'b01;

    fbe = 2'b00;
    if ((e_q.rt != 5'd0) && m_q.wr && (m_q.dst == e_q.rt))
      fbe = 2'b10;
    else if ((e_q.rt != 5'd0) && w_q.wr && (w_q.dst == e_q.rt))
      fbe = 2'b01;
  end

  assign hz.StallF     = stall;
  assign hz.StallD     = stall;
  assign hz.FlushE     = stall;
  assign hz.FlushD     = !reset && hz.PCSrcD && !stall;
  assign hz.ForwardAD  = !reset && fad;
  assign hz.ForwardBD  = !reset && fbd;
  assign hz.ForwardAE  = reset ? 2'b00 : fae;
  assign hz.ForwardBE  = reset ? 2'b00 : fbe;
  assign hz.StallCount = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= stall ? '0 : d_ent;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus
// randomized instruction streams against an instruction-level model.
module tb_hazard_unit;

  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  int n_tests = 0;
  int n_fail = 0;

  hazard_if #(.STALL_CNT_W(W)) hz ();

  hazard_unit #(.STALL_CNT_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz.slave)
  );

  always #5 clk = ~clk;

  // in-flight instructions: 0=E, 1=M, 2=W; bubble = zero word, class 00
  logic [31:0] pw [3];
  logic [1:0]  pt [3];
  int cnt;

  logic o_stall, o_fd, o_fad, o_fbd;
  logic [1:0] o_fae, o_fbe;
  int o_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(int s, int t, int d);
    logic [4:0] a, b, c;
    a = 5'(s); b = 5'(t); c = 5'(d);
    return {6'd0, a, b, c, 11'd0};
  endfunction

  function automatic logic [31:0] itype(int o, int s, int t);
    logic [5:0] p;
    logic [4:0] a, b;
    p = 6'(o); a = 5'(s); b = 5'(t);
    return {p, a, b, 16'h0010};
  endfunction

  function automatic int f_rs(logic [31:0] w); return int'(w[25:21]); endfunction
  function automatic int f_rt(logic [31:0] w); return int'(w[20:16]); endfunction
  function automatic int f_op(logic [31:0] w); return int'(w[31:26]); endfunction

  function automatic bit reads_rs(logic [1:0] t);
    return t == 2'b10 || t == 2'b01;
  endfunction

  function automatic bit reads_rt(logic [31:0] w, logic [1:0] t);
    return t == 2'b10 ||
      (t == 2'b01 && (f_op(w) == 43 || f_op(w) == 4));
  endfunction

  function automatic bit writes(logic [31:0] w, logic [1:0] t);
    return t == 2'b10 || f_op(w) == 35;
  endfunction

  function automatic bit loads(logic [31:0] w, logic [1:0] t);
    return t != 2'b10 && f_op(w) == 35;
  endfunction

  // Destination register number, 0 when the instruction writes nothing.
  function automatic int dest(logic [31:0] w, logic [1:0] t);
    if (t == 2'b10) return int'(w[15:11]);
    if (f_op(w) == 35) return f_rt(w);
    return 0;
  endfunction

  function automatic int e_src(bit b);
    if (!b) return reads_rs(pt[0]) ? f_rs(pw[0]) : 0;
    return reads_rt(pw[0], pt[0]) ? f_rt(pw[0]) : 0;
  endfunction

  function automatic logic [1:0] fwd_e(int r);
    if (r == 0) return 2'b00;
    if (writes(pw[1], pt[1]) && dest(pw[1], pt[1]) == r) return 2'b10;
    if (writes(pw[2], pt[2]) && dest(pw[2], pt[2]) == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input logic [31:0] w, input logic [1:0] t,
                      input logic pc, input logic rst);
    bit st, ls, bs;
    int rs, rt, de, dm;
    logic efad, efbd;
    logic [1:0] efae, efbe;
    hz.InstructionD = w;
    hz.optype = t;
    hz.PCSrcD = pc;
    reset = rst;
    rs = f_rs(w);
    rt = f_rt(w);
    de = dest(pw[0], pt[0]);
    dm = dest(pw[1], pt[1]);
    ls = loads(pw[0], pt[0]) && de != 0 &&
         ((reads_rs(t) && rs == de) || (reads_rt(w, t) && rt == de));
    bs = t == 2'b01 && f_op(w) == 4 &&
         ((de != 0 && (de == rs || de == rt)) ||
          (loads(pw[1], pt[1]) && dm != 0 && (dm == rs || dm == rt)));
    st = !rst && (ls || bs);
    efad = !rst && rs != 0 && dm == rs && !loads(pw[1], pt[1]);
    efbd = !rst && rt != 0 && dm == rt && !loads(pw[1], pt[1]);
    efae = rst ? 2'b00 : fwd_e(e_src(0));
    efbe = rst ? 2'b00 : fwd_e(e_src(1));
    @(negedge clk);
    o_stall = hz.StallD;
    o_fd = hz.FlushD;
    o_fad = hz.ForwardAD;
    o_fbd = hz.ForwardBD;
    o_fae = hz.ForwardAE;
    o_fbe = hz.ForwardBE;
    o_cnt = int'(hz.StallCount);
    chk("stalld", 32'(hz.StallD), 32'(st));
    chk("stallf", 32'(hz.StallF), 32'(st));
    chk("flushe", 32'(hz.FlushE), 32'(st));
    chk("flushd", 32'(hz.FlushD), 32'(!rst && pc && !st));
    chk("fwd_ad", 32'(hz.ForwardAD), 32'(efad));
    chk("fwd_bd", 32'(hz.ForwardBD), 32'(efbd));
    chk("fwd_ae", 32'(hz.ForwardAE), 32'(efae));
    chk("fwd_be", 32'(hz.ForwardBE), 32'(efbe));
    chk("count", 32'(hz.StallCount), 32'(cnt));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pw[i] = '0;
        pt[i] = '0;
      end
      cnt = 0;
    end else begin
      pw[2] = pw[1]; pt[2] = pt[1];
      pw[1] = pw[0]; pt[1] = pt[0];
      pw[0] = st ? 32'd0 : w;
      pt[0] = st ? 2'b00 : t;
      if (st && cnt < CMAX) cnt++;
    end
    #1;
  endtask

  task automatic nop(input logic rst);
    step(32'd0, 2'b00, 1'b0, rst);
  endtask

  task automatic do_reset();
    nop(1'b1);
    nop(1'b1);
  endtask

  logic [31:0] rw;
  logic [1:0]  rtp;

  initial begin
    for (int i = 0; i < 3; i++) begin
      pw[i] = '0;
      pt[i] = '0;
    end
    cnt = 0;
    reset = 1'b1;
    hz.InstructionD = '0;
    hz.optype = '0;
    hz.PCSrcD = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_cnt", 32'(o_cnt), 32'd0);

    // load-use
    step(itype(35, 1, 2), 2'b01, 1'b0, 1'b0);
    step(rtype(2, 4, 3), 2'b10, 1'b0, 1'b0);
    chk("t1_stall", 32'(o_stall), 32'd1);
    step(rtype(2, 4, 3), 2'b10, 1'b0, 1'b0);
    chk("t1_nostall", 32'(o_stall), 32'd0);
    nop(1'b0);
    chk("t1_fae", 32'(o_fae), 32'd1);
    chk("t1_fbe", 32'(o_fbe), 32'd0);
    chk("t1_cnt", 32'(o_cnt), 32'd1);

    // ALU-ALU forwarding from M
    do_reset();
    step(rtype(1, 1, 2), 2'b10, 1'b0, 1'b0);
    step(rtype(2, 2, 5), 2'b10, 1'b0, 1'b0);
    chk("t2_stall", 32'(o_stall), 32'd0);
    nop(1'b0);
    chk("t2_fae", 32'(o_fae), 32'd2);
    chk("t2_fbe", 32'(o_fbe), 32'd2);

    // branch after ALU producer
    do_reset();
    step(rtype(1, 1, 2), 2'b10, 1'b0, 1'b0);
    step(itype(4, 2, 3), 2'b01, 1'b0, 1'b0);
    chk("t3_stall", 32'(o_stall), 32'd1);
    step(itype(4, 2, 3), 2'b01, 1'b0, 1'b0);
    chk("t3_go", 32'(o_stall), 32'd0);
    chk("t3_fad", 32'(o_fad), 32'd1);
    chk("t3_fbd", 32'(o_fbd), 32'd0);

    // branch after load: two stall cycles
    do_reset();
    step(itype(35, 1, 2), 2'b01, 1'b0, 1'b0);
    step(itype(4, 2, 3), 2'b01, 1'b0, 1'b0);
    chk("t3l_s1", 32'(o_stall), 32'd1);
    step(itype(4, 2, 3), 2'b01, 1'b0, 1'b0);
    chk("t3l_s2", 32'(o_stall), 32'd1);
    step(itype(4, 2, 3), 2'b01, 1'b0, 1'b0);
    chk("t3l_go", 32'(o_stall), 32'd0);
    chk("t3l_cnt", 32'(o_cnt), 32'd2);

    // register 0
    do_reset();
    step(rtype(1, 1, 0), 2'b10, 1'b0, 1'b0);
    step(rtype(0, 0, 3), 2'b10, 1'b0, 1'b0);
    chk("t4_stall", 32'(o_stall), 32'd0);
    nop(1'b0);
    chk("t4_fae", 32'(o_fae), 32'd0);
    chk("t4_fbe", 32'(o_fbe), 32'd0);

    // taken branch flush vs stall
    do_reset();
    step(32'd0, 2'b00, 1'b1, 1'b0);
    chk("t5_flush", 32'(o_fd), 32'd1);
    step(rtype(1, 1, 2), 2'b10, 1'b0, 1'b0);
    step(itype(4, 2, 3), 2'b01, 1'b1, 1'b0);
    chk("t5_noflush", 32'(o_fd), 32'd0);
    chk("t5_stall", 32'(o_stall), 32'd1);

    // reset during a load-use stall
    do_reset();
    step(itype(35, 1, 2), 2'b01, 1'b0, 1'b0);
    step(rtype(2, 4, 3), 2'b10, 1'b0, 1'b1);
    chk("t6_rst_stall", 32'(o_stall), 32'd0);
    nop(1'b0);
    chk("t6_stall", 32'(o_stall), 32'd0);
    chk("t6_fae", 32'(o_fae), 32'd0);
    chk("t6_cnt", 32'(o_cnt), 32'd0);

    // counter saturation
    for (int i = 0; i < CMAX + 4; i++) begin
      step(itype(35, 1, 2), 2'b01, 1'b0, 1'b0);
      step(rtype(2, 4, 3), 2'b10, 1'b0, 1'b0);
    end
    nop(1'b0);
    chk("t6_sat", 32'(o_cnt), 32'(CMAX));

    // random streams over a small register set
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: begin rw = rtype($urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3)); rtp = 2'b10; end
        1: begin rw = itype(35, $urandom_range(0, 3),
                            $urandom_range(0, 3)); rtp = 2'b01; end
        2: begin rw = itype(43, $urandom_range(0, 3),
                            $urandom_range(0, 3)); rtp = 2'b01; end
        3: begin rw = itype(4, $urandom_range(0, 3),
                            $urandom_range(0, 3)); rtp = 2'b01; end
        4: begin rw = itype($urandom_range(8, 15), $urandom_range(0, 3),
                            $urandom_range(0, 3)); rtp = 2'b00; end
        default: begin rw = $urandom; rtp = 2'($urandom_range(0, 3)); end
      endcase
      step(rw, rtp, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
